// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK transmit datapath.
package bpsk_pkg;

  localparam int BPSK_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SEND  = 2'd2
  } framer_state_t;

endpackage

// File: rtl/bpsk_diff_encoder.sv
// Differential (DBPSK) bit encoder: out = ref ^ bit, ref follows out.
// clr zeroes the reference (and the output); when clr and adv coincide the
// new bit is encoded against a cleared reference.
module bpsk_diff_encoder (
  input  logic clk,
  input  logic rst,
  input  logic clken,
  input  logic clr,
  input  logic adv,
  input  logic bit_in,
  output logic bit_out
);

  logic ref_bit;
  logic enc;

  assign enc = adv ? ((clr ? 1'b0 : ref_bit) ^ bit_in) : 1'b0;

  // Reference and output update together at every bit boundary or clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_bit <= 1'b0;
      bit_out <= 1'b0;
    end else if (clken && (clr || adv)) begin
      ref_bit <= enc;
      bit_out <= enc;
    end
  end

endmodule

// File: rtl/bpsk_bit_framer.sv
// Byte-to-bit framer for the BPSK mixer. One-byte holding register ahead of
// an 8-bit shifter; bit edges land only on sine-period ticks.
// Optional build macro: BPSK_DIFF_EN selects differential (DBPSK) encoding.
module bpsk_bit_framer
  import bpsk_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 4,
  parameter bit MSB_FIRST      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       sine_rdy,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       data,
  output logic       mod_ena,
  output logic       busy
);

  localparam int TW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CYCLES_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(BPSK_BYTE_W - 1);

  framer_state_t          state, state_n;
  logic [BPSK_BYTE_W-1:0] hold, shift, shift_n;
  logic                   hold_full, hold_full_n;
  logic [2:0]             bit_cnt, bit_cnt_n;
  logic [TW-1:0]          tick_cnt, tick_cnt_n;
  logic                   ready_q, busy_q;
  logic                   acc, load, step, cur_n;

  function automatic logic cur_bit(input logic [BPSK_BYTE_W-1:0] s);
    return MSB_FIRST ? s[BPSK_BYTE_W-1] : s[0];
  endfunction

  function automatic logic [BPSK_BYTE_W-1:0] next_shift(input logic [BPSK_BYTE_W-1:0] s);
    return MSB_FIRST ? {s[BPSK_BYTE_W-2:0], 1'b0} : {1'b0, s[BPSK_BYTE_W-1:1]};
  endfunction

  // Acceptance ignores clken so the producer is never stalled by the mixer.
  assign acc = byte_valid & ready_q;

  // Next-state, counters and shifter; everything but acceptance waits for clken.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_cnt_n  = bit_cnt;
    tick_cnt_n = tick_cnt;
    load       = 1'b0;
    step       = 1'b0;
    if (clken) begin
      case (state)
        // A tick already present while IDLE acts as the ALIGN tick, so the
        // first bit starts one edge after the first tick following accept.
        IDLE:  if (hold_full) begin
                 if (sine_rdy) load = 1'b1;
                 else          state_n = ALIGN;
               end
        ALIGN: if (sine_rdy) load = 1'b1;
        SEND:  if (sine_rdy) begin
                 if (tick_cnt == TICK_LAST) begin
                   tick_cnt_n = '0;
                   if (bit_cnt != BIT_LAST) step    = 1'b1;
                   else if (hold_full)      load    = 1'b1;
                   else                     state_n = IDLE;
                 end else begin
                   tick_cnt_n = tick_cnt + 1'b1;
                 end
               end
        default: state_n = IDLE;
      endcase
    end
    if (step) begin
      bit_cnt_n = bit_cnt + 3'd1;
      shift_n   = next_shift(shift);
    end
    if (load) begin
      state_n    = SEND;
      shift_n    = hold;
      bit_cnt_n  = '0;
      tick_cnt_n = '0;
    end
    // load needs hold_full and acc needs it empty, so they never collide.
    hold_full_n = load ? 1'b0 : (acc ? 1'b1 : hold_full);
    cur_n       = (state_n == SEND) ? cur_bit(shift_n) : 1'b0;
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      tick_cnt  <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      mod_ena   <= 1'b0;
    end else begin
      state     <= state_n;
      hold_full <= hold_full_n;
      shift     <= shift_n;
      bit_cnt   <= bit_cnt_n;
      tick_cnt  <= tick_cnt_n;
      ready_q   <= ~hold_full_n;
      busy_q    <= (state_n != IDLE) || hold_full_n;
      mod_ena   <= (state_n == SEND);
      if (acc) hold <= byte_in;
    end
  end

  assign byte_ready = ready_q;
  assign busy       = busy_q;

`ifdef BPSK_DIFF_EN
  logic enc_clr, enc_adv;

  // Reference restarts at the beginning and end of every burst.
  assign enc_clr = clken && (((state == IDLE) && (state_n != IDLE)) ||
                             ((state == SEND) && (state_n == IDLE)));
  assign enc_adv = load | step;

  bpsk_diff_encoder u_enc (
    .clk     (clk),
    .rst     (rst),
    .clken   (clken),
    .clr     (enc_clr),
    .adv     (enc_adv),
    .bit_in  (cur_n),
    .bit_out (data)
  );
`else
  logic data_q;

  // Raw shifter bit, forced low outside SEND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= 1'b0;
    else      data_q <= cur_n;
  end

  assign data = data_q;
`endif

endmodule

// File: tb/tb_bpsk_bit_framer.sv
// Directed bench for bpsk_bit_framer: u_dut (CPB=4, MSB first) and
// u_dut2 (CPB=1, LSB first). sine_rdy strobes every 8 enabled cycles.
module tb_bpsk_bit_framer;

  logic       clk = 1'b0, rst = 1'b0, clken = 1'b1;
  logic       sine_rdy;
  logic [7:0] byte_in = 8'h00, byte_in2 = 8'h00;
  logic       byte_valid = 1'b0, byte_valid2 = 1'b0;
  logic       byte_ready, data, mod_ena, busy;
  logic       byte_ready2, data2, mod_ena2, busy2;
  int         sc;

  always #5 clk = ~clk;

  // Sine generator shares clken: its period counter freezes with the framer.
  always @(posedge clk or negedge rst)
    if (!rst)       sc <= 0;
    else if (clken) sc <= (sc == 7) ? 0 : sc + 1;
  assign sine_rdy = (sc == 7);

  bpsk_bit_framer #(.CYCLES_PER_BIT(4), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .clken(clken), .sine_rdy(sine_rdy),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .data(data), .mod_ena(mod_ena), .busy(busy));

  bpsk_bit_framer #(.CYCLES_PER_BIT(1), .MSB_FIRST(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .clken(clken), .sine_rdy(sine_rdy),
    .byte_in(byte_in2), .byte_valid(byte_valid2), .byte_ready(byte_ready2),
    .data(data2), .mod_ena(mod_ena2), .busy(busy2));

  int   n_chk = 0, n_pass = 0;
  logic cap [0:1023];
  int   cap_n, hi_n, frz_err;
  logic br_rise;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic me(input int d);
    return d != 0 ? mod_ena2 : mod_ena;
  endfunction
  function automatic logic dt(input int d);
    return d != 0 ? data2 : data;
  endfunction
  function automatic logic rdy(input int d);
    return d != 0 ? byte_ready2 : byte_ready;
  endfunction

  // Expected transmit order (first bit at MSB of the nb*8-bit result).
  // bytes2 = {first_byte, second_byte}.
  function automatic logic [15:0] model(input logic [15:0] bytes2, input int nb, input bit msb);
    logic [15:0] o;
    logic r, b;
    o = '0; r = 1'b0;
    for (int i = 0; i < nb; i++)
      for (int k = 0; k < 8; k++) begin
        b = msb ? bytes2[15-8*i-k] : bytes2[8-8*i+k];
`ifdef BPSK_DIFF_EN
        r = r ^ b;
        b = r;
`endif
        o[15-(8*i+k)] = b;
      end
    return (nb == 1) ? (o >> 8) : o;
  endfunction

  task automatic send(input int d, input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!rdy(d) && t < 2000) begin @(negedge clk); t++; end
    chk("ready_wait", t < 2000, 1);
    if (d != 0) begin byte_in2 = b; byte_valid2 = 1'b1; end
    else        begin byte_in  = b; byte_valid  = 1'b1; end
    @(negedge clk);
    byte_valid = 1'b0; byte_valid2 = 1'b0;
    chk("ready_drop", rdy(d), 0);
  endtask

  task automatic wait_rise(input int d);
    int t;
    t = 0;
    while (!me(d) && t < 2000) begin @(negedge clk); t++; end
    chk("rise_wait", t < 2000, 1);
  endtask

  // Records data once per enabled cycle while mod_ena is high; cycles with
  // clken low must repeat the previous value.
  task automatic capture(input int d, input int maxc);
    int t;
    t = 0; cap_n = 0; hi_n = 0; frz_err = 0;
    while (!me(d) && t < 2000) begin @(posedge clk); #1; t++; end
    chk("rise", t < 2000, 1);
    br_rise = rdy(d);
    while (me(d) && hi_n < maxc) begin
      if (clken) begin cap[cap_n] = dt(d); cap_n++; end
      else if (cap_n > 0 && dt(d) !== cap[cap_n-1]) frz_err++;
      hi_n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_stream(input string tag, input int nb, input int per, input logic [15:0] exp);
    logic [15:0] obs;
    int err;
    obs = '0; err = 0;
    for (int k = 0; k < nb; k++) begin
      obs[nb-1-k] = cap[k*per + per/2];
      for (int j = 0; j < per; j++)
        if (cap[k*per + j] !== cap[k*per + per/2]) err++;
    end
    chk(tag, obs, exp);
    chk({tag, "_hold"}, err, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_mod_ena", mod_ena, 0);
    chk("rst_ready", byte_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready2", byte_ready2, 1);
    rst = 1'b1;

    // Single byte 0xA5: 1,0,1,0,0,1,0,1 at 32 cycles per bit.
    send(0, 8'hA5);
    capture(0, 600);
    chk("a5_len", hi_n, 256);
    chk("a5_ready_at_align", br_rise, 1);
    check_stream("a5_bits", 8, 32, model(16'hA500, 1, 1'b1));
    repeat (3) @(negedge clk);
    chk("a5_busy_after", busy, 0);

    // Back-to-back 0xFF, 0x00; second accepted during bit 3.
    fork
      capture(0, 1200);
      begin
        send(0, 8'hFF);
        wait_rise(0);
        repeat (100) @(negedge clk);
        send(0, 8'h00);
      end
    join
    chk("b2b_len", hi_n, 512);
    check_stream("b2b_bits", 16, 32, model(16'hFF00, 2, 1'b1));

    // clken low 20 cycles during bit 1: frozen outputs, bit timing in ticks kept.
    send(0, 8'h96);
    fork
      capture(0, 600);
      begin
        wait_rise(0);
        repeat (50) @(negedge clk);
        clken = 1'b0;
        repeat (20) @(negedge clk);
        clken = 1'b1;
      end
    join
    chk("stall_len", hi_n, 276);
    chk("stall_samples", cap_n, 256);
    chk("stall_frozen", frz_err, 0);
    check_stream("stall_bits", 8, 32, model(16'h9600, 1, 1'b1));

    // Reset during bit 5 with a byte waiting in hold.
    send(0, 8'hA5);
    wait_rise(0);
    send(0, 8'h11);
    repeat (165) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_mod_ena", mod_ena, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_mod_ena", mod_ena, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_ready", byte_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    send(0, 8'h3C);
    capture(0, 600);
    chk("post_rst_len", hi_n, 256);
    check_stream("post_rst_bits", 8, 32, model(16'h3C00, 1, 1'b1));
    repeat (40) @(negedge clk);
    chk("lost_hold_idle", {busy, mod_ena}, 2'b00);

`ifdef BPSK_DIFF_EN
    // DBPSK: 0x0F -> 0,0,0,0,1,0,1,0 then 0x80 -> all ones (ref carried).
    fork
      capture(0, 1200);
      begin
        send(0, 8'h0F);
        wait_rise(0);
        repeat (100) @(negedge clk);
        send(0, 8'h80);
      end
    join
    chk("diff_len", hi_n, 512);
    check_stream("diff_bits", 16, 32, 16'h0AFF);
`endif

    // LSB first, one sine period (8 cycles) per bit: 0x01 -> 1 then seven 0s.
    send(1, 8'h01);
    capture(1, 300);
    chk("lsb_len", hi_n, 64);
    check_stream("lsb_bits", 8, 8, model(16'h0100, 1, 1'b0));
    repeat (3) @(negedge clk);
    chk("lsb_busy_after", busy2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
